dmem_responder: RTL and testbench

- Memory-side responder for the core's load/store port (ren, wen, addr, wdata, wlen, rdata).
- Models an on-chip data SRAM with a configurable access latency and a valid/ready request handshake, so the core can move from a combinational DPI memory to a real multi-cycle memory.
- Byte-lane writes are driven by wlen. Reads always return the raw aligned doubleword; lane extraction and sign extension remain in the core's load path.

---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port: an on-chip SRAM with a
// fixed access latency, a valid/ready request handshake and byte-lane writes.
module dmem_responder #(
  parameter int             DW      = 64,
  parameter int             AW      = 64,
  parameter int             DEPTH   = 4096,
  parameter logic [AW-1:0]  BASE    = 64'h8000_0000,
  parameter int             LATENCY = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_ren,
  input  logic          i_wen,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic [3:0]    i_wlen,
  output logic          o_resp_valid,
  output logic [DW-1:0] o_rdata,
  output logic          o_resp_err
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt, w_cntNext;
  logic          r_ren, r_wen;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_wlen;
  logic          r_respValid, r_respErr;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_accept, w_ren, w_wen, w_err, w_lenOk, w_cross;
  logic [AW-1:0] w_addr, w_off;
  logic [DW-1:0] w_wdata, w_old, w_shData, w_merged;
  logic [3:0]    w_wlen;
  logic [IW-1:0] w_index;
  logic [7:0]    w_lenMask, w_byteMask;

  // In IDLE the live inputs describe the request; afterwards the latched copy does.
  assign w_ren   = (r_state == S_IDLE) ? i_ren   : r_ren;
  assign w_wen   = (r_state == S_IDLE) ? i_wen   : r_wen;
  assign w_addr  = (r_state == S_IDLE) ? i_addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? i_wdata : r_wdata;
  assign w_wlen  = (r_state == S_IDLE) ? i_wlen  : r_wlen;

  assign w_accept = (r_state == S_IDLE) & i_req_valid & (i_ren | i_wen);
  assign w_off    = w_addr - BASE;
  assign w_index  = w_off[IW+2:3];
  assign w_lenOk  = (w_wlen == 4'd1) | (w_wlen == 4'd2) | (w_wlen == 4'd4) | (w_wlen == 4'd8);
  assign w_cross  = ({2'b00, w_off[2:0]} + {1'b0, w_wlen}) > 5'd8;
  assign w_err    = (w_addr < BASE) | (w_off[AW-1:3] >= (AW-3)'(DEPTH)) |
                    (w_ren & w_wen) | (w_wen & (~w_lenOk | w_cross));

  assign w_old    = r_mem[w_index];
  assign w_shData = w_wdata << {w_off[2:0], 3'b000};

  always_comb begin
    w_lenMask = 8'h00;
    case (w_wlen)
      4'd1:    w_lenMask = 8'h01;
      4'd2:    w_lenMask = 8'h03;
      4'd4:    w_lenMask = 8'h0F;
      4'd8:    w_lenMask = 8'hFF;
      default: w_lenMask = 8'h00;
    endcase
  end

  assign w_byteMask = w_lenMask << w_off[2:0];

  always_comb begin
    w_merged = w_old;
    for (int b = 0; b < 8; b++) begin
      if (w_byteMask[b]) w_merged[b*8 +: 8] = w_shData[b*8 +: 8];
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cntNext = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cntNext = 4'(LATENCY - 1);
          w_next    = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) w_next = S_RESP;
        else               w_cntNext = r_cnt - 4'd1;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Response outputs are loaded on the edge entering RESP so they are valid during RESP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_ren       <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wlen      <= 4'd0;
      r_respValid <= 1'b0;
      r_respErr   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cntNext;
      if (w_accept) begin
        r_ren   <= i_ren;
        r_wen   <= i_wen;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_wlen  <= i_wlen;
      end
      r_respValid <= (w_next == S_RESP);
      r_respErr   <= (w_next == S_RESP) & w_err;
      r_rdata     <= ((w_next == S_RESP) & w_ren & ~w_err) ? w_old : '0;
    end
  end

  // The store commits on the edge that closes RESP; a reset there drops it.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (r_state == S_RESP) && w_wen && !w_err) begin
      r_mem[w_index] <= w_merged;
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = r_respValid;
  assign o_resp_err   = r_respErr;
  assign o_rdata      = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (latency 1, 2, 4) share one
// stimulus bus; each test watches the outputs of the instance it targets.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, ren, wen;
  logic [63:0] addr, wdata;
  logic [3:0]  wlen;

  logic        rdyL1, respL1, errL1;
  logic [63:0] rdataL1;
  logic        rdyL2, respL2, errL2;
  logic [63:0] rdataL2;
  logic        rdyL4, respL4, errL4;
  logic [63:0] rdataL4;

  int          checks = 0;
  int          errors = 0;
  int          curSel = 2;
  logic        selReady, selResp, selErr;
  logic [63:0] selRdata;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(1)) dutL1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid), .o_req_ready(rdyL1),
    .i_ren(ren), .i_wen(wen), .i_addr(addr), .i_wdata(wdata), .i_wlen(wlen),
    .o_resp_valid(respL1), .o_rdata(rdataL1), .o_resp_err(errL1));

  dmem_responder #(.LATENCY(2)) dutL2 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid), .o_req_ready(rdyL2),
    .i_ren(ren), .i_wen(wen), .i_addr(addr), .i_wdata(wdata), .i_wlen(wlen),
    .o_resp_valid(respL2), .o_rdata(rdataL2), .o_resp_err(errL2));

  dmem_responder #(.LATENCY(4)) dutL4 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid), .o_req_ready(rdyL4),
    .i_ren(ren), .i_wen(wen), .i_addr(addr), .i_wdata(wdata), .i_wlen(wlen),
    .o_resp_valid(respL4), .o_rdata(rdataL4), .o_resp_err(errL4));

  always_comb begin
    selReady = rdyL2; selResp = respL2; selErr = errL2; selRdata = rdataL2;
    case (curSel)
      1: begin selReady = rdyL1; selResp = respL1; selErr = errL1; selRdata = rdataL1; end
      4: begin selReady = rdyL4; selResp = respL4; selErr = errL4; selRdata = rdataL4; end
      default: ;
    endcase
  end

  typedef struct {
    logic        ren;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  wlen;
    logic        chkData;
    logic [63:0] expData;
    logic        expErr;
  } vec_t;

  vec_t vecs[23];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Issues one request to the selected instance and reports latency, response and pulse shape.
  task automatic applyStimulus(input int sel, input logic r, input logic w,
                               input logic [63:0] a, input logic [63:0] d, input logic [3:0] l,
                               output logic [63:0] gotData, output logic gotErr,
                               output int gotLat, output logic pulseOk);
    int guard;
    curSel  = sel;
    gotData = '0; gotErr = 1'b0; gotLat = -1; pulseOk = 1'b0;
    @(negedge clk);
    ren = r; wen = w; addr = a; wdata = d; wlen = l; reqValid = 1'b1;
    guard = 0;
    while (!selReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!selReady) begin
      reqValid = 1'b0;
      return;
    end
    @(negedge clk);
    reqValid = 1'b0; ren = 1'b0; wen = 1'b0;
    guard = 1;
    while (!selResp && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!selResp) return;
    gotLat  = guard;
    gotData = selRdata;
    gotErr  = selErr;
    @(negedge clk);
    pulseOk = !selResp && !selErr && (selRdata == 64'h0) && selReady;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [63:0] gotData;
    logic        gotErr, pulseOk;
    int          gotLat;
    logic [63:0] b2bWord;

    vecs[0]  = '{1'b1, 1'b0, 64'h8000_0000, 64'h0,                  4'd8, 1'b0, 64'h0,                  1'b0};
    vecs[1]  = '{1'b0, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 4'd8, 1'b1, 64'h0,                  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 64'h8000_0010, 64'h0,                  4'd8, 1'b1, 64'h1122_3344_5566_7788, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 64'h8000_0013, 64'hAB,                 4'd1, 1'b1, 64'h0,                  1'b0};
    vecs[4]  = '{1'b1, 1'b0, 64'h8000_0010, 64'h0,                  4'd8, 1'b1, 64'h1122_3344_AB66_7788, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 64'h8000_0016, 64'hCAFE,               4'd2, 1'b1, 64'h0,                  1'b0};
    vecs[6]  = '{1'b1, 1'b0, 64'h8000_0016, 64'h0,                  4'd8, 1'b1, 64'hCAFE_3344_AB66_7788, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FF11, 4'd1, 1'b1, 64'h0,                  1'b0};
    vecs[8]  = '{1'b1, 1'b0, 64'h8000_0017, 64'h0,                  4'd8, 1'b1, 64'hCAFE_3344_AB66_7711, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 4'd8, 1'b1, 64'h0,                  1'b0};
    vecs[10] = '{1'b0, 1'b1, 64'h8000_0006, 64'hDEAD_BEEF,          4'd4, 1'b1, 64'h0,                  1'b1};
    vecs[11] = '{1'b1, 1'b1, 64'h8000_0000, 64'h0,                  4'd8, 1'b1, 64'h0,                  1'b1};
    vecs[12] = '{1'b0, 1'b1, 64'h8000_0000, 64'h55,                 4'd3, 1'b1, 64'h0,                  1'b1};
    vecs[13] = '{1'b1, 1'b0, 64'h8000_0000, 64'h0,                  4'd8, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 64'h7FFF_FFF8, 64'h0,                  4'd8, 1'b1, 64'h0,                  1'b1};
    vecs[15] = '{1'b0, 1'b1, 64'h8000_0004, 64'hA1B2_C3D4,          4'd4, 1'b1, 64'h0,                  1'b0};
    vecs[16] = '{1'b1, 1'b0, 64'h8000_0000, 64'h0,                  4'd8, 1'b1, 64'hA1B2_C3D4_89AB_CDEF, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 64'h8000_7FF8, 64'hFEDC_BA98_7654_3210, 4'd8, 1'b1, 64'h0,                  1'b0};
    vecs[18] = '{1'b1, 1'b0, 64'h8000_7FFC, 64'h0,                  4'd8, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 64'h8000_8000, 64'h0,                  4'd8, 1'b1, 64'h0,                  1'b1};
    vecs[20] = '{1'b0, 1'b1, 64'h8000_8000, 64'h12,                 4'd1, 1'b1, 64'h0,                  1'b1};
    vecs[21] = '{1'b0, 1'b1, 64'h8000_0017, 64'hBEEF,               4'd2, 1'b1, 64'h0,                  1'b1};
    vecs[22] = '{1'b1, 1'b0, 64'h8000_0010, 64'h0,                  4'd8, 1'b1, 64'hCAFE_3344_AB66_7711, 1'b0};

    rst = 1'b1; reqValid = 1'b0; ren = 1'b0; wen = 1'b0;
    addr = '0; wdata = '0; wlen = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetOutputs", {60'h0, rdyL2, respL2, errL2, |rdataL2}, 64'h8);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleAfterReset", {61'h0, rdyL1, rdyL2, rdyL4}, 64'h7);

    for (int i = 0; i < 23; i++) begin
      applyStimulus(2, vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wlen,
                    gotData, gotErr, gotLat, pulseOk);
      checkOutput($sformatf("vec%0d.latency", i), 64'(gotLat), 64'd2);
      checkOutput($sformatf("vec%0d.err", i), {63'h0, gotErr}, {63'h0, vecs[i].expErr});
      if (vecs[i].chkData) checkOutput($sformatf("vec%0d.rdata", i), gotData, vecs[i].expData);
      checkOutput($sformatf("vec%0d.pulseEnd", i), {63'h0, pulseOk}, 64'h1);
    end

    // A valid with neither ren nor wen must never be accepted.
    curSel = 2;
    @(negedge clk);
    reqValid = 1'b1; ren = 1'b0; wen = 1'b0; addr = 64'h8000_0000;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checkOutput($sformatf("ignoredReq.c%0d", n), {62'h0, respL2, rdyL2}, 64'h1);
    end
    reqValid = 1'b0;

    // Held request: accepts only in IDLE, responses spaced LATENCY+1 apart.
    b2bWord = 64'hCAFE_3344_AB66_7711;
    @(negedge clk);
    reqValid = 1'b1; ren = 1'b1; wen = 1'b0; addr = 64'h8000_0010;
    for (int n = 0; n <= 10; n++) begin
      logic expRdy, expResp;
      if (n > 0) @(negedge clk);
      if (n == 7) begin reqValid = 1'b0; ren = 1'b0; end
      expRdy  = (n <= 6) ? (n % 3 == 0) : (n >= 9);
      expResp = (n <= 8) && (n % 3 == 2);
      checkOutput($sformatf("backToBack.c%0d.ready", n), {63'h0, rdyL2}, {63'h0, expRdy});
      checkOutput($sformatf("backToBack.c%0d.resp", n), {63'h0, respL2}, {63'h0, expResp});
      checkOutput($sformatf("backToBack.c%0d.rdata", n), rdataL2, expResp ? b2bWord : 64'h0);
    end

    applyStimulus(1, 1'b0, 1'b1, 64'h8000_0020, 64'h1111_2222_3333_4444, 4'd8,
                  gotData, gotErr, gotLat, pulseOk);
    checkOutput("lat1Write.latency", 64'(gotLat), 64'd1);
    checkOutput("lat1Write.err", {63'h0, gotErr}, 64'h0);
    checkOutput("lat1Write.pulseEnd", {63'h0, pulseOk}, 64'h1);
    applyStimulus(1, 1'b1, 1'b0, 64'h8000_0020, 64'h0, 4'd8, gotData, gotErr, gotLat, pulseOk);
    checkOutput("lat1Read.latency", 64'(gotLat), 64'd1);
    checkOutput("lat1Read.rdata", gotData, 64'h1111_2222_3333_4444);
    checkOutput("lat1Read.pulseEnd", {63'h0, pulseOk}, 64'h1);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    applyStimulus(4, 1'b0, 1'b1, 64'h8000_0100, 64'h0A0B_0C0D_0E0F_1011, 4'd8,
                  gotData, gotErr, gotLat, pulseOk);
    checkOutput("lat4Write.latency", 64'(gotLat), 64'd4);
    checkOutput("lat4Write.err", {63'h0, gotErr}, 64'h0);

    // Reset while a latency-4 write is in flight: no response, no commit.
    curSel = 4;
    @(negedge clk);
    reqValid = 1'b1; ren = 1'b0; wen = 1'b1; addr = 64'h8000_0100;
    wdata = 64'hFFFF_EEEE_DDDD_CCCC; wlen = 4'd8;
    checkOutput("midReset.accepted", {63'h0, rdyL4}, 64'h1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin reqValid = 1'b0; wen = 1'b0; end
      if (c == 2) rst = 1'b1;
      if (c == 3) rst = 1'b0;
      checkOutput($sformatf("midReset.c%0d.resp", c), {63'h0, respL4}, 64'h0);
      if (c >= 3) checkOutput($sformatf("midReset.c%0d.ready", c), {63'h0, rdyL4}, 64'h1);
    end
    applyStimulus(4, 1'b1, 1'b0, 64'h8000_0100, 64'h0, 4'd8, gotData, gotErr, gotLat, pulseOk);
    checkOutput("midReset.readLatency", 64'(gotLat), 64'd4);
    checkOutput("midReset.oldWord", gotData, 64'h0A0B_0C0D_0E0F_1011);
    checkOutput("midReset.readErr", {63'h0, gotErr}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
